pc_redirect_unit: RTL and testbench

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/pc_target_calc.sv | 46 ++++
 rtl/pc_redirect_unit.sv | 145 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types for the fetch-PC redirect logic.
//   xlen_t           : 32-bit machine word.
//   state_t          : redirect FSM states (RUN, FLUSH).
//   RESET_PC_DEFAULT : default PC loaded on reset.
//   cnt_t            : 3-bit flush cycle counter (FLUSH_CYCLES is 1..7).
package riscv_pkg;

  typedef logic [31:0] xlen_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam xlen_t RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc -- combinational redirect target selection.
// Optional feature macro: PC_MISALIGN_TRAP_EN (adds the misaligned output).
// Ports:
//   branch_taken, jal_en, jalr_en : redirect sources from EX
//   pc_ex, rs1, imm               : operands for the target adders
//   req                           : any redirect source is active
//   target                        : prioritised target (jalr > jal > branch)
//   misaligned                    : target[1] set (only with PC_MISALIGN_TRAP_EN)
module pc_target_calc
  import riscv_pkg::*;
(
  input  logic  branch_taken,
  input  logic  jal_en,
  input  logic  jalr_en,
  input  xlen_t pc_ex,
  input  xlen_t rs1,
  input  xlen_t imm,
  output logic  req,
`ifdef PC_MISALIGN_TRAP_EN
  output logic  misaligned,
`endif
  output xlen_t target
);

  xlen_t pc_rel;
  xlen_t reg_rel;

  // Both adders wrap modulo 2^32; carry out is intentionally dropped.
  assign pc_rel  = pc_ex + imm;
  assign reg_rel = (rs1 + imm) & ~xlen_t'(1);

  assign req = branch_taken | jal_en | jalr_en;

  // jal and branch share the pc-relative adder, so only jalr needs a mux leg.
  always_comb begin
    target = pc_rel;
    if (jalr_en) begin
      target = reg_rel;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = target[1];
`endif

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit -- fetch PC register with branch/jump redirect and flush.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned target -> trap).
// Parameters:
//   RESET_PC     : PC loaded on reset
//   FLUSH_CYCLES : cycles flush stays high after a redirect (1..7)
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   stall                         : hold the PC (fetch back-pressure)
//   branch_taken, jal_en, jalr_en : redirect requests from EX
//   pc_ex, rs1, imm               : target operands
//   pc, pc_plus4                  : fetch PC and its link value
//   redirect                      : one-cycle pulse, PC loaded with a target
//   flush                         : squash younger instructions in IF/ID
//   trap                          : misaligned-target pulse (macro only)
//   state                         : FSM state, exported for debug
// Handshake: there is no valid/ready pair; requests are level inputs sampled
// on every rising edge while in RUN and ignored while in FLUSH.
module pc_redirect_unit
  import riscv_pkg::*;
#(
  parameter xlen_t RESET_PC     = RESET_PC_DEFAULT,
  parameter int    FLUSH_CYCLES = 2
)(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   branch_taken,
  input  logic   jal_en,
  input  logic   jalr_en,
  input  xlen_t  pc_ex,
  input  xlen_t  rs1,
  input  xlen_t  imm,
  output xlen_t  pc,
  output xlen_t  pc_plus4,
  output logic   redirect,
  output logic   flush,
`ifdef PC_MISALIGN_TRAP_EN
  output logic   trap,
`endif
  output state_t state
);

  localparam cnt_t LAST_CNT = cnt_t'(FLUSH_CYCLES - 1);

  state_t state_n;
  cnt_t   cnt;
  cnt_t   cnt_n;
  xlen_t  pc_n;
  xlen_t  seq_pc;
  logic   redirect_n;
  logic   req;
  xlen_t  target;
`ifdef PC_MISALIGN_TRAP_EN
  logic   misaligned;
  logic   trap_n;
`endif

  pc_target_calc u_target (
    .branch_taken (branch_taken),
    .jal_en       (jal_en),
    .jalr_en      (jalr_en),
    .pc_ex        (pc_ex),
    .rs1          (rs1),
    .imm          (imm),
    .req          (req),
`ifdef PC_MISALIGN_TRAP_EN
    .misaligned   (misaligned),
`endif
    .target       (target)
  );

  assign pc_plus4 = pc + 32'd4;
  assign seq_pc   = stall ? pc : pc_plus4;

  // flush is a pure decode of the state, so reset clears it immediately.
  assign flush = (state == FLUSH);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_n       = pc;
    redirect_n = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_n     = 1'b0;
`endif
    case (state)
      RUN: begin
        if (req) begin
          // A redirect wins over stall: the target is loaded regardless.
`ifdef PC_MISALIGN_TRAP_EN
          if (misaligned) begin
            trap_n = 1'b1;
          end else begin
            pc_n       = target;
            redirect_n = 1'b1;
          end
`else
          pc_n       = target;
          redirect_n = 1'b1;
`endif
          state_n = FLUSH;
          cnt_n   = '0;
        end else begin
          pc_n = seq_pc;
        end
      end
      FLUSH: begin
        // Shadow requests are dropped; stall only affects the PC, never
        // the flush countdown.
        pc_n = seq_pc;
        if (cnt == LAST_CNT) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + cnt_t'(1);
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      pc       <= RESET_PC;
      redirect <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pc       <= pc_n;
      redirect <= redirect_n;
`ifdef PC_MISALIGN_TRAP_EN
      trap     <= trap_n;
`endif
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit -- scoreboard bench for pc_redirect_unit.
// Optional feature macro: PC_MISALIGN_TRAP_EN (bench follows the RTL build).
module tb_pc_redirect_unit;
  import riscv_pkg::*;

  localparam xlen_t TB_RESET_PC = 32'h0000_0000;
  localparam int    FLUSH_N     = 2;
  localparam int    EW          = 35;  // {pc, redirect, flush, trap}

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   stall = 1'b0;
  logic   branch_taken = 1'b0;
  logic   jal_en = 1'b0;
  logic   jalr_en = 1'b0;
  xlen_t  pc_ex = '0;
  xlen_t  rs1 = '0;
  xlen_t  imm = '0;
  xlen_t  pc;
  xlen_t  pc_plus4;
  logic   redirect;
  logic   flush;
  state_t state_dbg;
`ifdef PC_MISALIGN_TRAP_EN
  logic   trap;
`endif

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC     (TB_RESET_PC),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jal_en       (jal_en),
    .jalr_en      (jalr_en),
    .pc_ex        (pc_ex),
    .rs1          (rs1),
    .imm          (imm),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .flush        (flush),
`ifdef PC_MISALIGN_TRAP_EN
    .trap         (trap),
`endif
    .state        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: PC value and number of flush cycles still owed
  xlen_t m_pc = TB_RESET_PC;
  int    m_flush_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic br, input logic jl, input logic jr,
                       input xlen_t pe, input xlen_t r1, input xlen_t im);
    xlen_t tgt;
    logic  rd;
    logic  tp;
    @(negedge clk);
    rst = 1'b0;
    stall = s; branch_taken = br; jal_en = jl; jalr_en = jr;
    pc_ex = pe; rs1 = r1; imm = im;
    rd = 1'b0;
    tp = 1'b0;
    if (m_flush_left == 0 && (br || jl || jr)) begin
      if (jr) tgt = (r1 + im) & 32'hFFFF_FFFE;
      else    tgt = pe + im;
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt[1]) tp = 1'b1;
      else begin m_pc = tgt; rd = 1'b1; end
`else
      m_pc = tgt;
      rd   = 1'b1;
`endif
      m_flush_left = FLUSH_N;
    end else begin
      if (!s) m_pc = m_pc + 32'd4;
      if (m_flush_left > 0) m_flush_left--;
    end
    exp_q.push_back({m_pc, rd, (m_flush_left > 0), tp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, holds n edges.
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; jal_en = 1'b0; jalr_en = 1'b0;
    #1;
    check("async_rst_pc", pc, TB_RESET_PC);
    check("async_rst_flush", {31'd0, flush}, 32'd0);
    check("async_rst_redirect", {31'd0, redirect}, 32'd0);
    m_pc = TB_RESET_PC;
    m_flush_left = 0;
    for (int i = 0; i < n; i++) exp_q.push_back({TB_RESET_PC, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < n - 1; i++) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e[34:3]);
        check("pc_plus4", pc_plus4, e[34:3] + 32'd4);
        check("redirect", {31'd0, redirect}, {31'd0, e[2]});
        check("flush", {31'd0, flush}, {31'd0, e[1]});
        check("state", {31'd0, state_dbg == FLUSH}, {31'd0, e[1]});
`ifdef PC_MISALIGN_TRAP_EN
        check("trap", {31'd0, trap}, {31'd0, e[0]});
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic s, br, jl, jr;
    xlen_t im;

    apply_reset(2);

    // sequential fetch from reset
    idle(3);

    // backward branch, then requests during flush must be ignored
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hFFFF_FFF0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h800, 32'h3000, 32'h40);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h40);
    idle(1);

    // jalr beats jal, bit 0 cleared
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h2001, 32'h4);
    idle(2);

    // redirect beats stall; then stall in RUN holds the PC
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // wrap of the sequential PC and of the target adder
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h20);
    idle(2);

    // reset in the first flush cycle aborts the flush
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0);
    apply_reset(1);
    idle(3);

    // target with bit 1 set (trap build holds the PC)
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h2);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset($urandom_range(1, 2));
      end else begin
        s  = ($urandom_range(0, 3) == 0);
        br = ($urandom_range(0, 5) == 0);
        jl = ($urandom_range(0, 7) == 0);
        jr = ($urandom_range(0, 7) == 0);
        im = $urandom();
        if ($urandom_range(0, 1) == 0) im[1:0] = 2'b00;
        drive(s, br, jl, jr, $urandom(), $urandom(), im);
      end
    end

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
